// File: rtl/simmem_wrsp_bank.sv
// Write-response bank for the simulated memory: each write reserves a slot, the real
// response fills it, and the delay calculator decides when it is released downstream.
module simmem_wrsp_bank #(
    parameter int NumSlots = 8,
    parameter int IdW      = 4,
    parameter int RspW     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rsv_valid_i,
    output logic                        rsv_ready_o,
    input  logic [IdW-1:0]              rsv_id_i,
    output logic [$clog2(NumSlots)-1:0] rsv_iid_o,
    input  logic                        rsp_valid_i,
    output logic                        rsp_ready_o,
    input  logic [IdW-1:0]              rsp_id_i,
    input  logic [RspW-1:0]             rsp_data_i,
    input  logic [NumSlots-1:0]         release_en_mhot_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [IdW-1:0]              out_id_o,
    output logic [RspW-1:0]             out_data_o,
    output logic [NumSlots-1:0]         released_iid_onehot_o,
    output logic [2*NumSlots-1:0]       dbg_slot_state_o
);
    localparam int IiW = $clog2(NumSlots);

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_RESERVED  = 2'd1,
        SLOT_FILLED    = 2'd2,
        SLOT_RELEASING = 2'd3
    } slot_state_e;

    slot_state_e         r_state [NumSlots];
    logic [IdW-1:0]      r_id    [NumSlots];
    logic [RspW-1:0]     r_data  [NumSlots];
    // r_older[i][j] = 1 means slot i was reserved before slot j
    logic [NumSlots-1:0] r_older [NumSlots];
    logic                r_out_valid;
    logic [IdW-1:0]      r_out_id;
    logic [RspW-1:0]     r_out_data;
    logic [NumSlots-1:0] r_out_sel;

    logic [NumSlots-1:0] w_free, w_busy, w_rsp_cand, w_elig, w_rsp_sel, w_out_sel;
    logic [IiW-1:0]      w_rsv_iid;
    logic [IdW-1:0]      w_sel_id;
    logic [RspW-1:0]     w_sel_data;
    logic                w_rsv_fire, w_rsp_fire, w_out_fire, w_out_load;

    always_comb begin
        w_free     = '0;
        w_busy     = '0;
        w_rsp_cand = '0;
        w_elig     = '0;
        w_rsp_sel  = '0;
        w_out_sel  = '0;
        w_rsv_iid  = '0;
        w_sel_id   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_free[i]     = (r_state[i] == SLOT_FREE);
            w_busy[i]     = (r_state[i] == SLOT_RESERVED) || (r_state[i] == SLOT_FILLED);
            w_rsp_cand[i] = (r_state[i] == SLOT_RESERVED) && (r_id[i] == rsp_id_i);
        end
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (w_free[i]) w_rsv_iid = IiW'(i);
        end
        // A filled slot waits behind any older same-id slot that has not been released yet.
        for (int i = 0; i < NumSlots; i++) begin
            w_elig[i] = (r_state[i] == SLOT_FILLED) && release_en_mhot_i[i];
            for (int j = 0; j < NumSlots; j++) begin
                if (j != i && w_busy[j] && r_id[j] == r_id[i] && r_older[j][i]) w_elig[i] = 1'b0;
            end
        end
        for (int i = 0; i < NumSlots; i++) begin
            w_rsp_sel[i] = w_rsp_cand[i];
            w_out_sel[i] = w_elig[i];
            for (int j = 0; j < NumSlots; j++) begin
                if (j != i && w_rsp_cand[j] && r_older[j][i]) w_rsp_sel[i] = 1'b0;
                if (j != i && w_elig[j] && r_older[j][i])     w_out_sel[i] = 1'b0;
            end
        end
        for (int i = 0; i < NumSlots; i++) begin
            if (w_out_sel[i]) begin
                w_sel_id   = w_sel_id | r_id[i];
                w_sel_data = w_sel_data | r_data[i];
            end
        end
    end

    // Every channel transfers exactly on a cycle where valid and ready are both high at the
    // rising edge; ready never depends on the same channel's valid.
    assign w_rsv_fire = rsv_valid_i & (|w_free);
    assign w_rsp_fire = rsp_valid_i & (|w_rsp_cand);
    assign w_out_fire = r_out_valid & out_ready_i;
    assign w_out_load = ~r_out_valid | w_out_fire;

    assign rsv_ready_o           = |w_free;
    assign rsv_iid_o             = w_rsv_iid;
    assign rsp_ready_o           = |w_rsp_cand;
    assign out_valid_o           = r_out_valid;
    assign out_id_o              = r_out_id;
    assign out_data_o            = r_out_data;
    assign released_iid_onehot_o = w_out_fire ? r_out_sel : '0;

    always_comb begin
        dbg_slot_state_o = '0;
        for (int i = 0; i < NumSlots; i++) dbg_slot_state_o[2*i +: 2] = r_state[i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                r_state[i] <= SLOT_FREE;
                r_id[i]    <= '0;
                r_data[i]  <= '0;
                r_older[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else begin
            // The four transitions start from four different states, so they never collide.
            for (int i = 0; i < NumSlots; i++) begin
                if (w_rsv_fire && w_rsv_iid == IiW'(i)) begin
                    r_state[i] <= SLOT_RESERVED;
                    r_id[i]    <= rsv_id_i;
                    r_older[i] <= '0;
                end else begin
                    if (w_rsp_fire && w_rsp_sel[i]) begin
                        r_state[i] <= SLOT_FILLED;
                        r_data[i]  <= rsp_data_i;
                    end else if (w_out_load && w_out_sel[i]) begin
                        r_state[i] <= SLOT_RELEASING;
                    end else if (w_out_fire && r_out_sel[i]) begin
                        r_state[i] <= SLOT_FREE;
                    end
                    for (int j = 0; j < NumSlots; j++) begin
                        if (w_rsv_fire && w_rsv_iid == IiW'(j)) r_older[i][j] <= ~w_free[i];
                    end
                end
            end
            if (w_out_load) begin
                r_out_valid <= |w_out_sel;
                r_out_id    <= w_sel_id;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_out_sel;
            end
        end
    end
endmodule

// File: tb/tb_simmem_wrsp_bank.sv
// Directed bench for simmem_wrsp_bank: timestamp-ordered slot model checked every cycle,
// plus literal expectations for the reference scenarios.
module tb_simmem_wrsp_bank;
  localparam int N = 8;
  localparam int IW = 4;
  localparam int DW = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic rsv_valid_i = 1'b0;
  logic rsv_ready_o;
  logic [IW-1:0] rsv_id_i = '0;
  logic [2:0] rsv_iid_o;
  logic rsp_valid_i = 1'b0;
  logic rsp_ready_o;
  logic [IW-1:0] rsp_id_i = '0;
  logic [DW-1:0] rsp_data_i = '0;
  logic [N-1:0] release_en_mhot_i = '0;
  logic out_valid_o;
  logic out_ready_i = 1'b0;
  logic [IW-1:0] out_id_o;
  logic [DW-1:0] out_data_o;
  logic [N-1:0] released_iid_onehot_o;
  logic [2*N-1:0] dbg_slot_state_o;

  simmem_wrsp_bank #(.NumSlots(N), .IdW(IW), .RspW(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rsv_valid_i(rsv_valid_i), .rsv_ready_o(rsv_ready_o), .rsv_id_i(rsv_id_i), .rsv_iid_o(rsv_iid_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_id_i(rsp_id_i), .rsp_data_i(rsp_data_i),
    .release_en_mhot_i(release_en_mhot_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o), .out_data_o(out_data_o),
    .released_iid_onehot_o(released_iid_onehot_o), .dbg_slot_state_o(dbg_slot_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // slot model: 0 free, 1 reserved, 2 filled, 3 releasing; age = reservation timestamp
  int m_st [N];
  int m_id [N];
  int m_data [N];
  int m_seq [N];
  int seq_ctr = 0;
  bit m_ov = 1'b0;
  int m_oslot = 0;
  int m_oid = 0;
  int m_odata = 0;

  always @(negedge clk_i) begin
    int e_iid, tgt, ld;
    bit e_rsv_rdy, e_rsp_rdy, fire, el;
    logic [N-1:0] e_rel;
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_ov = 1'b0;
    end
    e_rsv_rdy = 1'b0;
    e_iid = 0;
    for (int i = N - 1; i >= 0; i--) if (m_st[i] == 0) begin e_rsv_rdy = 1'b1; e_iid = i; end
    e_rsp_rdy = 1'b0;
    tgt = -1;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1 && m_id[i] == int'(rsp_id_i)) begin
        e_rsp_rdy = 1'b1;
        if (tgt < 0 || m_seq[i] < m_seq[tgt]) tgt = i;
      end
    end
    fire = m_ov && out_ready_i;
    e_rel = fire ? N'(1 << m_oslot) : '0;
    chk("rsv_ready", rsv_ready_o, e_rsv_rdy);
    if (e_rsv_rdy) chk("rsv_iid", rsv_iid_o, e_iid);
    chk("rsp_ready", rsp_ready_o, e_rsp_rdy);
    chk("out_valid", out_valid_o, m_ov);
    chk("out_id", out_id_o, m_ov ? m_oid : 0);
    chk("out_data", out_data_o, m_ov ? m_odata : 0);
    chk("released", released_iid_onehot_o, e_rel);
    if (rst_ni) begin
      ld = -1;
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 2 && release_en_mhot_i[i]) begin
          el = 1'b1;
          for (int j = 0; j < N; j++)
            if (j != i && (m_st[j] == 1 || m_st[j] == 2) && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) el = 1'b0;
          if (el && (ld < 0 || m_seq[i] < m_seq[ld])) ld = i;
        end
      end
      if (rsv_valid_i && e_rsv_rdy) begin
        m_st[e_iid] = 1; m_id[e_iid] = int'(rsv_id_i); m_seq[e_iid] = seq_ctr; seq_ctr++;
      end
      if (rsp_valid_i && tgt >= 0) begin m_st[tgt] = 2; m_data[tgt] = int'(rsp_data_i); end
      if (fire) m_st[m_oslot] = 0;
      if (!m_ov || fire) begin
        if (ld >= 0) begin
          m_ov = 1'b1; m_oslot = ld; m_oid = m_id[ld]; m_odata = m_data[ld]; m_st[ld] = 3;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rsv_valid_i = 1'b0; rsp_valid_i = 1'b0; out_ready_i = 1'b0; release_en_mhot_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    tick();
    @(negedge clk_i);
    chk("rst_dbg_free", dbg_slot_state_o, 0);
    chk("rst_rsv_ready", rsv_ready_o, 1);
    chk("rst_rsv_iid", rsv_iid_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic reserve(input int id, input int exp_iid);
    rsv_valid_i = 1'b1;
    rsv_id_i = IW'(id);
    @(negedge clk_i);
    chk("lit_rsv_iid", rsv_iid_o, exp_iid);
    tick();
    rsv_valid_i = 1'b0;
  endtask

  task automatic respond(input int id, input int data);
    rsp_valid_i = 1'b1;
    rsp_id_i = IW'(id);
    rsp_data_i = DW'(data);
    @(negedge clk_i);
    chk("lit_rsp_ready", rsp_ready_o, 1);
    tick();
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // single response through one slot
    reserve(3, 0);
    respond(3, 2);
    release_en_mhot_i = 8'h01;
    @(negedge clk_i); chk("s1_no_out_yet", out_valid_o, 0);
    tick();
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("s1_out_valid", out_valid_o, 1);
    chk("s1_out_id", out_id_o, 3);
    chk("s1_out_data", out_data_o, 2);
    chk("s1_released", released_iid_onehot_o, 8'h01);
    tick();
    clear_inputs();
    @(negedge clk_i);
    chk("s1_reservable", rsv_ready_o, 1);
    chk("s1_iid_back", rsv_iid_o, 0);
    chk("s1_rel_idle", released_iid_onehot_o, 0);
    tick();

    // same-id ordering
    do_reset();
    reserve(5, 0);
    reserve(5, 1);
    respond(5, 1);
    respond(5, 2);
    release_en_mhot_i = 8'h02;
    repeat (3) begin @(negedge clk_i); chk("s2_blocked", out_valid_o, 0); tick(); end
    release_en_mhot_i = 8'h03;
    out_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("s2_first_data", out_data_o, 1);
    chk("s2_first_rel", released_iid_onehot_o, 8'h01);
    tick();
    @(negedge clk_i);
    chk("s2_second_data", out_data_o, 2);
    chk("s2_second_rel", released_iid_onehot_o, 8'h02);
    tick();
    clear_inputs();
    @(negedge clk_i); chk("s2_drained", out_valid_o, 0);
    tick();

    // different ids are not ordered
    do_reset();
    reserve(1, 0);
    reserve(2, 1);
    respond(1, 3);
    respond(2, 1);
    release_en_mhot_i = 8'h02;
    out_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("s3_first_id", out_id_o, 2);
    chk("s3_first_rel", released_iid_onehot_o, 8'h02);
    tick();
    release_en_mhot_i = 8'h01;
    tick();
    @(negedge clk_i);
    chk("s3_second_id", out_id_o, 1);
    chk("s3_second_data", out_data_o, 3);
    tick();
    clear_inputs();

    // full bank
    do_reset();
    for (int i = 0; i < N; i++) reserve(i, i);
    @(negedge clk_i); chk("s4_full", rsv_ready_o, 0);
    tick();
    respond(5, 3);
    release_en_mhot_i = 8'h20;
    out_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("s4_rel", released_iid_onehot_o, 8'h20);
    chk("s4_still_full", rsv_ready_o, 0);
    tick();
    clear_inputs();
    @(negedge clk_i);
    chk("s4_ready_again", rsv_ready_o, 1);
    chk("s4_iid_freed", rsv_iid_o, 5);
    tick();

    // presented response held under backpressure; then all three handshakes at once
    do_reset();
    reserve(7, 0);
    reserve(9, 1);
    reserve(4, 2);
    respond(9, 2);
    respond(7, 1);
    release_en_mhot_i = 8'h02;
    tick();
    repeat (5) begin
      release_en_mhot_i = 8'h03;
      @(negedge clk_i);
      chk("s5_held_valid", out_valid_o, 1);
      chk("s5_held_id", out_id_o, 9);
      chk("s5_held_data", out_data_o, 2);
      tick();
    end
    out_ready_i = 1'b1;
    rsv_valid_i = 1'b1; rsv_id_i = 4'd6;
    rsp_valid_i = 1'b1; rsp_id_i = 4'd4; rsp_data_i = 2'd3;
    @(negedge clk_i);
    chk("s5_rel", released_iid_onehot_o, 8'h02);
    chk("s5_rsv_iid", rsv_iid_o, 3);
    chk("s5_rsp_ready", rsp_ready_o, 1);
    tick();
    rsv_valid_i = 1'b0; rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("s5_next_id", out_id_o, 7);
    chk("s5_next_data", out_data_o, 1);
    chk("s5_next_rel", released_iid_onehot_o, 8'h01);
    tick();
    clear_inputs();

    // reset in the middle of operation
    do_reset();
    reserve(1, 0);
    reserve(2, 1);
    reserve(3, 2);
    reserve(4, 3);
    respond(1, 1);
    respond(2, 2);
    respond(3, 3);
    respond(4, 0);
    release_en_mhot_i = 8'h0F;
    tick();
    @(negedge clk_i); chk("s6_presented", out_valid_o, 1);
    tick();
    rst_ni = 1'b0;
    out_ready_i = 1'b1;
    #1;
    chk("s6_async_valid", out_valid_o, 0);
    chk("s6_async_rel", released_iid_onehot_o, 0);
    chk("s6_async_rsp_ready", rsp_ready_o, 0);
    chk("s6_async_rsv_ready", rsv_ready_o, 1);
    chk("s6_async_iid", rsv_iid_o, 0);
    tick();
    clear_inputs();
    rst_ni = 1'b1;
    reserve(8, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
